sgd_model_writeback_engine: RTL and testbench
=============================================

// Module: sgd_model_writeback_engine
// PURPOSE
//  Next-generation model write-back: streams the updated x vector from the banked per-engine model memory to host memory.
//  Emits burst commands (addr/length) and OUT_W-bit data beats over valid/ready handshakes.
//  Single clock; the downstream DMA shim owns any CDC. Sits between the SGD engines' x memory and the host-write DMA port.
// PARAMETERS
//  ENGINE_NUM      8     engines (banks) read in parallel per row
//  BANK_W          2048  bits per engine per row; must be a multiple of OUT_W
//  OUT_W           512   output beat width
//  ADDR_W          9     x-memory row address width
//  RD_LAT          2     x-memory read latency, cycles (1..4)
//  FIFO_DEPTH      8     output skid FIFO depth; must be >= RD_LAT+2
//  MAX_BURST_BEATS 64    max beats per command
// PORTS
//  clk             in   1                clock
//  rst_n           in   1                async active-low reset
//  wb_start        in   1                pulse: begin one write-back pass
//  addr_model      in   64               host byte base address
//  addr_stride     in   64               byte offset added per completed pass
//  dimension       in   32               feature count, sampled at wb_start
//  wb_busy         out  1                pass in progress
//  wb_done         out  1                1-cycle pulse at pass end
//  wb_err_zero_dim out  1                sticky: start seen with dimension==0; cleared by next valid start
//  wb_pass_cnt     out  32               completed passes
//  x_mem_rd_addr   out  ADDR_W           row address
//  x_mem_rd_en     out  1                read strobe
//  x_mem_rd_data   in   ENGINE_NUM*BANK_W  row data, RD_LAT after strobe
//  cmd_valid/cmd_ready  out/in  1        command handshake
//  cmd_addr        out  64               burst byte address
//  cmd_len         out  32               burst length, bytes
//  out_valid/out_ready  out/in  1        data handshake
//  out_data        out  OUT_W            beat
//  perf_cmd_cnt, perf_beat_cnt, perf_stall_cnt  out  32  see CONFIGURATION
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, FIFO empty, pass/perf counters 0, wb_err_zero_dim 0.
//  - SLICES = BANK_W/OUT_W; FEAT_PER_ROW = ENGINE_NUM*BANK_W/32.
//  - ROWS = ceil(dimension/FEAT_PER_ROW); TOTAL = ROWS*ENGINE_NUM*SLICES beats. Arithmetic is 32-bit unsigned.
//  - Beat order: row-major, then engine 0..ENGINE_NUM-1, then slice 0..SLICES-1. Slice s = bits [s*OUT_W +: OUT_W].
//  - FSM states: IDLE -> CMD -> DATA -> (CMD | DRAIN) -> IDLE.
//  - IDLE: wb_start with dimension!=0 latches base = addr_model + wb_pass_cnt*addr_stride and goes to CMD; wb_busy=1.
//    wb_start with dimension==0: set error flag, pulse wb_done next cycle, no command.
//  - CMD: cmd_valid=1, addr = base + beat_off*(OUT_W/8), len = min(MAX_BURST_BEATS, remaining)*(OUT_W/8).
//    Fields stay stable until cmd_ready; then go to DATA.
//  - DATA: one x_mem_rd_en per beat, same row address across the engine/slice sweep.
//    Issue only while fifo_count + in_flight < FIFO_DEPTH (credit rule; no overflow, no data loss).
//    Engine/slice tags are delayed RD_LAT cycles to select the slice.
//    After the burst's last read: go to CMD if beats remain, else DRAIN.
//    A command is never issued before all data of the previous burst has been read.
//  - DRAIN: wait FIFO empty and in_flight==0; then wb_done=1 for one cycle, wb_pass_cnt++, wb_busy=0, go IDLE.
//  - Output: out_valid is asserted from the FIFO not-empty flag. out_data is held stable while out_valid & ~out_ready.
//    Zero-bubble throughput when out_ready=1.
//  - wb_start while busy is ignored. Simultaneous cmd and data handshakes are legal.
//    wb_pass_cnt wraps at 2^32. Reset mid-pass aborts immediately; FIFO contents are discarded.
// CONFIGURATION
//  SGD_WB_PERF_CNT_EN defined: perf_cmd_cnt counts cmd handshakes, perf_beat_cnt counts out handshakes,
//    perf_stall_cnt counts cycles with out_valid & ~out_ready. All are async-reset and free-running.
//  SGD_WB_PERF_CNT_EN undefined: perf_* ports are tied to 0 and no counter logic is built.
// STRUCTURE
//  Package sgd_wb_pkg: state enum (IDLE, CMD, DATA, DRAIN), beat-tag struct {engine, slice}, SLICES/FEAT_PER_ROW helper functions.
//  Sub-module sgd_wb_skid_fifo: synchronous FIFO, OUT_W x FIFO_DEPTH, exposes count. Main module holds FSM, address gen, credit logic.
// TESTING (ENGINE_NUM=2, BANK_W=1024, OUT_W=512, RD_LAT=2, FIFO_DEPTH=4; 4 beats/row, 64 features/row)
//  1. dimension=64, base=0x1000, ready=1 -> one cmd addr=0x1000 len=256.
//     4 beats in order e0s0,e0s1,e1s0,e1s1; wb_done 1 cycle after FIFO drains.
//  2. dimension=65 -> cmd len=512, 8 beats, rows 0 and 1 read.
//  3. MAX_BURST_BEATS=4, dimension=128 -> cmds (0x1000,256) then (0x1100,256); second cmd only after first burst's reads.
//  4. out_ready pattern 1,0,0,1 repeated, dimension=128 -> 8 beats exact, no dup/loss, out_data stable during stalls;
//     FIFO never exceeds 4; perf_stall_cnt matches stall cycles (macro on).
//  5. dimension=0 -> wb_err_zero_dim=1, wb_done pulse, no cmd_valid; next valid start clears error.
//  6. addr_stride=0x400: second pass cmd addr=0x1400, wb_pass_cnt=2.
//     rst_n low mid-DATA -> all outputs 0 asynchronously; a clean pass follows.

Source files
------------

// File: rtl/sgd_wb_pkg.sv
// Shared types and helpers for the model write-back engine: FSM state
// encoding, the engine/slice tag carried alongside each x-memory read,
// and geometry helpers used to size the beat sweep.
package sgd_wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CMD   = 2'd1,
        ST_DATA  = 2'd2,
        ST_DRAIN = 2'd3
    } wb_state_e;

    localparam int TAG_W = 8;

    typedef struct packed {
        logic [TAG_W-1:0] engine;
        logic [TAG_W-1:0] slice;
    } beat_tag_t;

    // Number of OUT_W-bit slices in one engine's bank word.
    function automatic int slices_f(input int bank_w, input int out_w);
        return bank_w / out_w;
    endfunction

    // Number of 32-bit features held by one x-memory row across all engines.
    function automatic int feat_per_row_f(input int engine_num, input int bank_w);
        return (engine_num * bank_w) / 32;
    endfunction

endpackage

// File: rtl/sgd_wb_skid_fifo.sv
// Synchronous output skid FIFO for the write-back engine. Storage is not
// reset; only pointers and occupancy are. The producer guarantees via
// credits that pushes never hit a full FIFO, the full guard is a backstop.
module sgd_wb_skid_fifo #(
    parameter int WIDTH = 512,
    parameter int DEPTH = 8,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign push    = wr_en && (count_q != CNT_W'(DEPTH));
    assign pop     = rd_en && !empty;
    assign rd_data = mem_q[rd_ptr_q];

    // Data storage: written on push, never reset.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data;
    end

    // Pointer and occupancy bookkeeping; simultaneous push/pop keeps count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
        end
    end

endmodule

// File: rtl/sgd_model_writeback_engine.sv
// Model write-back engine: sweeps the banked x memory row by row, engine by
// engine, slice by slice, and streams OUT_W-bit beats to host memory behind
// burst commands. Reads are credit-limited so the skid FIFO never overflows.
// Optional feature macro: SGD_WB_PERF_CNT_EN builds the performance counters;
// without it the perf_* ports are tied to zero.
module sgd_model_writeback_engine
    import sgd_wb_pkg::*;
#(
    parameter int ENGINE_NUM      = 8,
    parameter int BANK_W          = 2048,
    parameter int OUT_W           = 512,
    parameter int ADDR_W          = 9,
    parameter int RD_LAT          = 2,
    parameter int FIFO_DEPTH      = 8,
    parameter int MAX_BURST_BEATS = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wb_start,
    input  logic [63:0]                  addr_model,
    input  logic [63:0]                  addr_stride,
    input  logic [31:0]                  dimension,
    output logic                         wb_busy,
    output logic                         wb_done,
    output logic                         wb_err_zero_dim,
    output logic [31:0]                  wb_pass_cnt,
    output logic [ADDR_W-1:0]            x_mem_rd_addr,
    output logic                         x_mem_rd_en,
    input  logic [ENGINE_NUM*BANK_W-1:0] x_mem_rd_data,
    output logic                         cmd_valid,
    input  logic                         cmd_ready,
    output logic [63:0]                  cmd_addr,
    output logic [31:0]                  cmd_len,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [OUT_W-1:0]             out_data,
    output logic [31:0]                  perf_cmd_cnt,
    output logic [31:0]                  perf_beat_cnt,
    output logic [31:0]                  perf_stall_cnt
);

    localparam int SLICES        = slices_f(BANK_W, OUT_W);
    localparam int FEAT_PER_ROW  = feat_per_row_f(ENGINE_NUM, BANK_W);
    localparam int BEAT_BYTES    = OUT_W / 8;
    localparam int BEATS_PER_ROW = ENGINE_NUM * SLICES;
    localparam int CNT_W         = $clog2(FIFO_DEPTH + 1);

    wb_state_e         state_q, state_d;
    logic [63:0]       base_q, base_d;
    logic [31:0]       total_q, total_d;
    logic [31:0]       beat_off_q, beat_off_d;
    logic [31:0]       burst_left_q, burst_left_d;
    logic [ADDR_W-1:0] row_q, row_d;
    beat_tag_t         tag_q, tag_d;
    logic [31:0]       pass_cnt_q, pass_cnt_d;
    logic              err_q, err_d;
    logic              done_q, done_d;

    beat_tag_t         tag_p [RD_LAT];
    logic [RD_LAT-1:0] vld_p;

    logic [31:0]       rows_calc, total_calc, remaining, burst_beats, in_flight;
    logic              issue, fifo_empty;
    logic [CNT_W-1:0]  fifo_cnt;
    logic [OUT_W-1:0]  wr_beat, fifo_head;

    // Pass geometry, burst sizing and the read credit check.
    always_comb begin
        rows_calc   = (dimension / 32'(FEAT_PER_ROW))
                    + (((dimension % 32'(FEAT_PER_ROW)) != 32'd0) ? 32'd1 : 32'd0);
        total_calc  = rows_calc * 32'(BEATS_PER_ROW);
        remaining   = total_q - beat_off_q;
        burst_beats = (remaining < 32'(MAX_BURST_BEATS)) ? remaining : 32'(MAX_BURST_BEATS);
        in_flight   = '0;
        for (int i = 0; i < RD_LAT; i++) in_flight = in_flight + 32'(vld_p[i]);
        issue = (state_q == ST_DATA) && ((32'(fifo_cnt) + in_flight) < 32'(FIFO_DEPTH));
    end

    // Next-state logic for the FSM, sweep counters and pass bookkeeping.
    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        total_d      = total_q;
        beat_off_d   = beat_off_q;
        burst_left_d = burst_left_q;
        row_d        = row_q;
        tag_d        = tag_q;
        pass_cnt_d   = pass_cnt_q;
        err_d        = err_q;
        done_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (wb_start) begin
                    if (dimension == 32'd0) begin
                        err_d  = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        err_d      = 1'b0;
                        base_d     = addr_model + (64'(pass_cnt_q) * addr_stride);
                        total_d    = total_calc;
                        beat_off_d = '0;
                        row_d      = '0;
                        tag_d      = '0;
                        state_d    = ST_CMD;
                    end
                end
            end
            ST_CMD: begin
                if (cmd_ready) begin
                    burst_left_d = burst_beats;
                    state_d      = ST_DATA;
                end
            end
            ST_DATA: begin
                if (issue) begin
                    beat_off_d   = beat_off_q + 32'd1;
                    burst_left_d = burst_left_q - 32'd1;
                    if (32'(tag_q.slice) == 32'(SLICES - 1)) begin
                        tag_d.slice = '0;
                        if (32'(tag_q.engine) == 32'(ENGINE_NUM - 1)) begin
                            tag_d.engine = '0;
                            row_d        = row_q + 1'b1;
                        end else begin
                            tag_d.engine = tag_q.engine + 1'b1;
                        end
                    end else begin
                        tag_d.slice = tag_q.slice + 1'b1;
                    end
                    if (burst_left_q == 32'd1)
                        state_d = (beat_off_d == total_q) ? ST_DRAIN : ST_CMD;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty && (in_flight == 32'd0)) begin
                    done_d     = 1'b1;
                    pass_cnt_d = pass_cnt_q + 32'd1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state and control registers; reset aborts any pass in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            base_q       <= '0;
            total_q      <= '0;
            beat_off_q   <= '0;
            burst_left_q <= '0;
            row_q        <= '0;
            tag_q        <= '0;
            pass_cnt_q   <= '0;
            err_q        <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            total_q      <= total_d;
            beat_off_q   <= beat_off_d;
            burst_left_q <= burst_left_d;
            row_q        <= row_d;
            tag_q        <= tag_d;
            pass_cnt_q   <= pass_cnt_d;
            err_q        <= err_d;
            done_q       <= done_d;
        end
    end

    // Read-valid pipeline matching the x-memory latency (control, reset).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= issue;
            for (int i = 1; i < RD_LAT; i++) vld_p[i] <= vld_p[i-1];
        end
    end

    // Engine/slice tag pipeline travelling with each read (data, no reset).
    always_ff @(posedge clk) begin
        tag_p[0] <= tag_q;
        for (int i = 1; i < RD_LAT; i++) tag_p[i] <= tag_p[i-1];
    end

    // Select the tagged slice out of the returned row.
    always_comb begin
        wr_beat = '0;
        for (int e = 0; e < ENGINE_NUM; e++) begin
            for (int s = 0; s < SLICES; s++) begin
                if ((32'(tag_p[RD_LAT-1].engine) == 32'(e)) && (32'(tag_p[RD_LAT-1].slice) == 32'(s)))
                    wr_beat = x_mem_rd_data[e*BANK_W + s*OUT_W +: OUT_W];
            end
        end
    end

    sgd_wb_skid_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (vld_p[RD_LAT-1]),
        .wr_data (wr_beat),
        .rd_en   (out_ready),
        .rd_data (fifo_head),
        .empty   (fifo_empty),
        .count   (fifo_cnt)
    );

    assign wb_busy         = (state_q != ST_IDLE);
    assign wb_done         = done_q;
    assign wb_err_zero_dim = err_q;
    assign wb_pass_cnt     = pass_cnt_q;
    assign x_mem_rd_en     = issue;
    assign x_mem_rd_addr   = row_q;
    assign cmd_valid       = (state_q == ST_CMD);
    assign cmd_addr        = cmd_valid ? (base_q + (64'(beat_off_q) * 64'(BEAT_BYTES))) : '0;
    assign cmd_len         = cmd_valid ? (burst_beats * 32'(BEAT_BYTES)) : '0;
    assign out_valid       = !fifo_empty;
    assign out_data        = out_valid ? fifo_head : '0;

`ifdef SGD_WB_PERF_CNT_EN
    logic [31:0] perf_cmd_q, perf_beat_q, perf_stall_q;

    // Free-running handshake and stall counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cmd_q   <= '0;
            perf_beat_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            if (cmd_valid && cmd_ready)  perf_cmd_q   <= perf_cmd_q + 32'd1;
            if (out_valid && out_ready)  perf_beat_q  <= perf_beat_q + 32'd1;
            if (out_valid && !out_ready) perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_cmd_cnt   = perf_cmd_q;
    assign perf_beat_cnt  = perf_beat_q;
    assign perf_stall_cnt = perf_stall_q;
`else
    assign perf_cmd_cnt   = '0;
    assign perf_beat_cnt  = '0;
    assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_sgd_model_writeback_engine.sv
// Directed bench for sgd_model_writeback_engine. Instance A uses the default
// burst limit; instance B limits bursts to 4 beats to exercise multi-command
// passes. Both share start/config inputs and have their own x-memory model.
module tb_sgd_model_writeback_engine;

    localparam int EN = 2, BW = 1024, OW = 512, AW = 9, RL = 2, FD = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, wb_start;
    logic [63:0]   addr_model, addr_stride;
    logic [31:0]   dimension;

    logic          a_busy, a_done, a_err, a_rd_en, a_cmd_valid, a_cmd_ready, a_out_valid, a_out_ready;
    logic [31:0]   a_pass, a_cmd_len, a_perf_cmd, a_perf_beat, a_perf_stall;
    logic [AW-1:0] a_rd_addr;
    logic [EN*BW-1:0] a_rd_data;
    logic [63:0]   a_cmd_addr;
    logic [OW-1:0] a_out_data;

    logic          b_busy, b_done, b_err, b_rd_en, b_cmd_valid, b_out_valid;
    logic          b_cmd_ready = 1'b1, b_out_ready = 1'b1;
    logic [31:0]   b_pass, b_cmd_len, b_perf_cmd, b_perf_beat, b_perf_stall;
    logic [AW-1:0] b_rd_addr;
    logic [EN*BW-1:0] b_rd_data;
    logic [63:0]   b_cmd_addr;
    logic [OW-1:0] b_out_data;

    sgd_model_writeback_engine #(.ENGINE_NUM(EN), .BANK_W(BW), .OUT_W(OW), .ADDR_W(AW),
        .RD_LAT(RL), .FIFO_DEPTH(FD), .MAX_BURST_BEATS(64)) dut_a (
        .clk(clk), .rst_n(rst_n), .wb_start(wb_start), .addr_model(addr_model),
        .addr_stride(addr_stride), .dimension(dimension), .wb_busy(a_busy), .wb_done(a_done),
        .wb_err_zero_dim(a_err), .wb_pass_cnt(a_pass), .x_mem_rd_addr(a_rd_addr),
        .x_mem_rd_en(a_rd_en), .x_mem_rd_data(a_rd_data), .cmd_valid(a_cmd_valid),
        .cmd_ready(a_cmd_ready), .cmd_addr(a_cmd_addr), .cmd_len(a_cmd_len),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .perf_cmd_cnt(a_perf_cmd), .perf_beat_cnt(a_perf_beat), .perf_stall_cnt(a_perf_stall));

    sgd_model_writeback_engine #(.ENGINE_NUM(EN), .BANK_W(BW), .OUT_W(OW), .ADDR_W(AW),
        .RD_LAT(RL), .FIFO_DEPTH(FD), .MAX_BURST_BEATS(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .wb_start(wb_start), .addr_model(addr_model),
        .addr_stride(addr_stride), .dimension(dimension), .wb_busy(b_busy), .wb_done(b_done),
        .wb_err_zero_dim(b_err), .wb_pass_cnt(b_pass), .x_mem_rd_addr(b_rd_addr),
        .x_mem_rd_en(b_rd_en), .x_mem_rd_data(b_rd_data), .cmd_valid(b_cmd_valid),
        .cmd_ready(b_cmd_ready), .cmd_addr(b_cmd_addr), .cmd_len(b_cmd_len),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .perf_cmd_cnt(b_perf_cmd), .perf_beat_cnt(b_perf_beat), .perf_stall_cnt(b_perf_stall));

    // Beat content: unique 32-bit words {word, row, engine, slice}; never all ones.
    function automatic logic [OW-1:0] beat_val(input int r, input int e, input int s);
        logic [OW-1:0] v;
        for (int w = 0; w < OW/32; w++) v[w*32 +: 32] = {8'(w), 8'(r), 8'(e), 8'(s)};
        return v;
    endfunction

    function automatic logic [EN*BW-1:0] row_val(input int r);
        logic [EN*BW-1:0] v;
        for (int e = 0; e < EN; e++)
            for (int s = 0; s < BW/OW; s++) v[e*BW + s*OW +: OW] = beat_val(r, e, s);
        return v;
    endfunction

    // x-memory models: data valid only RL cycles after a strobe, ones otherwise.
    logic [AW-1:0] a_addr_p1, a_addr_p2, b_addr_p1, b_addr_p2;
    logic          a_en_p1, a_en_p2, b_en_p1, b_en_p2;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_en_p1 <= 1'b0; a_en_p2 <= 1'b0; b_en_p1 <= 1'b0; b_en_p2 <= 1'b0;
        end else begin
            a_en_p1 <= a_rd_en; a_en_p2 <= a_en_p1; a_addr_p1 <= a_rd_addr; a_addr_p2 <= a_addr_p1;
            b_en_p1 <= b_rd_en; b_en_p2 <= b_en_p1; b_addr_p1 <= b_rd_addr; b_addr_p2 <= b_addr_p1;
        end
    end
    assign a_rd_data = a_en_p2 ? row_val(int'(a_addr_p2)) : {EN*BW{1'b1}};
    assign b_rd_data = b_en_p2 ? row_val(int'(b_addr_p2)) : {EN*BW{1'b1}};

    int n_tests = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitors, sampled on the falling edge.
    int cyc = 0, n_rd = 0, n_out = 0, max_occ = 0, stall_cnt = 0, beat_cnt = 0, cmd_cnt = 0;
    int done_cnt = 0, done_cyc = 0, last_hs_cyc = 0, n_cmd_valid = 0, unstable = 0;
    logic [OW-1:0] beat_q[$];
    int            rd_rows[$];
    logic [63:0]   cmd_addr_q[$];
    logic [31:0]   cmd_len_q[$];
    logic [63:0]   b_cmd_addr_q[$];
    logic [31:0]   b_cmd_len_q[$];
    int            b_cmd_cyc_q[$], b_rd_cyc_q[$];
    logic          prev_stall = 1'b0, prev_cwait = 1'b0;
    logic [OW-1:0] prev_data;
    logic [63:0]   prev_caddr;
    logic [31:0]   prev_clen;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            n_rd = 0; n_out = 0; stall_cnt = 0; beat_cnt = 0; cmd_cnt = 0;
            prev_stall = 1'b0; prev_cwait = 1'b0;
        end else begin
            if (a_rd_en) begin rd_rows.push_back(int'(a_rd_addr)); n_rd++; end
            if (a_out_valid && a_out_ready) begin
                beat_q.push_back(a_out_data); n_out++; beat_cnt++; last_hs_cyc = cyc;
            end
            if (a_out_valid && !a_out_ready) stall_cnt++;
            if (prev_stall && (!a_out_valid || a_out_data !== prev_data)) unstable++;
            prev_stall = a_out_valid && !a_out_ready;
            prev_data  = a_out_data;
            if (a_cmd_valid) n_cmd_valid++;
            if (a_cmd_valid && a_cmd_ready) begin
                cmd_addr_q.push_back(a_cmd_addr); cmd_len_q.push_back(a_cmd_len); cmd_cnt++;
            end
            if (prev_cwait && (!a_cmd_valid || a_cmd_addr !== prev_caddr || a_cmd_len !== prev_clen)) unstable++;
            prev_cwait = a_cmd_valid && !a_cmd_ready;
            prev_caddr = a_cmd_addr;
            prev_clen  = a_cmd_len;
            if (a_done) begin done_cnt++; done_cyc = cyc; end
            if (n_rd - n_out > max_occ) max_occ = n_rd - n_out;
            if (b_rd_en) b_rd_cyc_q.push_back(cyc);
            if (b_cmd_valid && b_cmd_ready) begin
                b_cmd_addr_q.push_back(b_cmd_addr); b_cmd_len_q.push_back(b_cmd_len);
                b_cmd_cyc_q.push_back(cyc);
            end
        end
    end

    // Ready driver: mode 1 gives out_ready 1,0,0,1 and cmd_ready 1-in-4.
    int ready_mode = 0;
    initial begin
        int ph;
        ph = 0;
        a_out_ready = 1'b1;
        a_cmd_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (ready_mode == 1) begin
                a_out_ready = (ph == 0) || (ph == 3);
                a_cmd_ready = (ph == 2);
                ph = (ph + 1) % 4;
            end else begin
                a_out_ready = 1'b1;
                a_cmd_ready = 1'b1;
                ph = 0;
            end
        end
    end

    int beat0, rd0, cmd0, done0, bcmd0, brd0, unst0, ncv0;

    task automatic snap();
        beat0 = beat_q.size(); rd0 = rd_rows.size(); cmd0 = cmd_addr_q.size();
        done0 = done_cnt; bcmd0 = b_cmd_addr_q.size(); brd0 = b_rd_cyc_q.size();
        unst0 = unstable; ncv0 = n_cmd_valid;
    endtask

    task automatic start_pass(input logic [31:0] dim);
        @(posedge clk); #1;
        dimension = dim;
        wb_start  = 1'b1;
        @(posedge clk); #1;
        wb_start  = 1'b0;
    endtask

    task automatic wait_pass(input string tag);
        int n;
        n = 0;
        while (done_cnt == done0 && n < 2000) begin @(posedge clk); n++; end
        chk({tag, "_done_seen"}, (done_cnt > done0), 1);
        n = 0;
        while (b_busy && n < 2000) begin @(posedge clk); n++; end
        chk({tag, "_b_idle"}, b_busy, 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_beats(input string tag, input int nb);
        chk({tag, "_nbeats"}, beat_q.size() - beat0, nb);
        chk({tag, "_nreads"}, rd_rows.size() - rd0, nb);
        for (int k = 0; k < nb; k++) begin
            if (beat0 + k < beat_q.size())
                chk($sformatf("%s_beat%0d", tag, k), beat_q[beat0 + k], beat_val(k/4, (k/2)%2, k%2));
            if (rd0 + k < rd_rows.size())
                chk($sformatf("%s_row%0d", tag, k), rd_rows[rd0 + k], k/4);
        end
    endtask

    task automatic check_cmd(input string tag, input int idx, input logic [63:0] ea, input logic [31:0] el);
        if (cmd0 + idx < cmd_addr_q.size()) begin
            chk({tag, "_cmd_addr"}, cmd_addr_q[cmd0 + idx], ea);
            chk({tag, "_cmd_len"}, cmd_len_q[cmd0 + idx], el);
        end else begin
            chk({tag, "_cmd_present"}, 0, 1);
        end
    endtask

    initial begin
        int n;
        rst_n = 1'b0; wb_start = 1'b0; dimension = '0;
        addr_model = 64'h1000; addr_stride = 64'h0;
        repeat (3) @(negedge clk);
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_err", a_err, 0);
        chk("rst_pass", a_pass, 0);
        chk("rst_cmd_valid", a_cmd_valid, 0);
        chk("rst_cmd_addr", a_cmd_addr, 0);
        chk("rst_cmd_len", a_cmd_len, 0);
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_out_data", a_out_data, 0);
        chk("rst_rd_en", a_rd_en, 0);
        chk("rst_perf", {a_perf_cmd, a_perf_beat, a_perf_stall}, 0);
        rst_n = 1'b1;

        // 1: one row, single burst.
        snap(); start_pass(32'd64); wait_pass("t1");
        chk("t1_ncmd", cmd_addr_q.size() - cmd0, 1);
        check_cmd("t1", 0, 64'h1000, 32'd256);
        check_beats("t1", 4);
        chk("t1_done_lat", done_cyc - last_hs_cyc, 2);
        chk("t1_done_pulses", done_cnt - done0, 1);
        chk("t1_pass", a_pass, 1);
        chk("t1_busy", a_busy, 0);

        // 2: one feature spills into a second row.
        snap(); start_pass(32'd65); wait_pass("t2");
        check_cmd("t2", 0, 64'h1000, 32'd512);
        check_beats("t2", 8);
        chk("t2_pass", a_pass, 2);

        // 3/4: back-pressure on A; burst splitting on B.
        ready_mode = 1;
        snap(); start_pass(32'd128); wait_pass("t4");
        ready_mode = 0;
        chk("t4_ncmd", cmd_addr_q.size() - cmd0, 1);
        check_cmd("t4", 0, 64'h1000, 32'd512);
        check_beats("t4", 8);
        chk("t4_stable", unstable - unst0, 0);
        chk("t4_fifo_bound", (max_occ <= FD), 1);
`ifdef SGD_WB_PERF_CNT_EN
        chk("t4_perf_stall", a_perf_stall, stall_cnt);
        chk("t4_perf_beat", a_perf_beat, beat_cnt);
        chk("t4_perf_cmd", a_perf_cmd, cmd_cnt);
`else
        chk("t4_perf_stall", a_perf_stall, 0);
        chk("t4_perf_beat", a_perf_beat, 0);
`endif
        chk("t3_ncmd", b_cmd_addr_q.size() - bcmd0, 2);
        if (b_cmd_addr_q.size() - bcmd0 >= 2 && b_rd_cyc_q.size() - brd0 >= 4) begin
            chk("t3_cmd0_addr", b_cmd_addr_q[bcmd0], 64'h1000);
            chk("t3_cmd0_len", b_cmd_len_q[bcmd0], 256);
            chk("t3_cmd1_addr", b_cmd_addr_q[bcmd0 + 1], 64'h1100);
            chk("t3_cmd1_len", b_cmd_len_q[bcmd0 + 1], 256);
            chk("t3_cmd1_after_reads", (b_cmd_cyc_q[bcmd0 + 1] > b_rd_cyc_q[brd0 + 3]), 1);
        end
        chk("t3_b_reads", b_rd_cyc_q.size() - brd0, 8);

        // 5: zero dimension.
        snap(); start_pass(32'd0); wait_pass("t5");
        chk("t5_err", a_err, 1);
        chk("t5_done_pulses", done_cnt - done0, 1);
        chk("t5_no_cmd", n_cmd_valid - ncv0, 0);
        chk("t5_pass", a_pass, 3);
        snap(); start_pass(32'd64);
        chk("t5_err_cleared", a_err, 0);
        wait_pass("t5b");
        check_beats("t5b", 4);
        chk("t5b_pass", a_pass, 4);

        // 6: stride between passes, then reset mid-pass.
        @(negedge clk); rst_n = 1'b0;
        addr_stride = 64'h400;
        repeat (2) @(negedge clk); rst_n = 1'b1;
        snap(); start_pass(32'd64); wait_pass("t6a");
        check_cmd("t6a", 0, 64'h1000, 32'd256);
        snap(); start_pass(32'd64); wait_pass("t6b");
        check_cmd("t6b", 0, 64'h1400, 32'd256);
        chk("t6b_pass", a_pass, 2);
        start_pass(32'd128);
        n = 0;
        while (!a_rd_en && n < 100) begin @(posedge clk); #1; n++; end
        chk("t6_reached_data", a_rd_en, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_abort_busy", a_busy, 0);
        chk("t6_abort_rd_en", a_rd_en, 0);
        chk("t6_abort_out_valid", a_out_valid, 0);
        chk("t6_abort_out_data", a_out_data, 0);
        chk("t6_abort_cmd_valid", a_cmd_valid, 0);
        chk("t6_abort_pass", a_pass, 0);
        repeat (2) @(negedge clk); rst_n = 1'b1;
        snap(); start_pass(32'd64); wait_pass("t6c");
        check_cmd("t6c", 0, 64'h1000, 32'd256);
        check_beats("t6c", 4);
        chk("t6c_pass", a_pass, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
